// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  // Responder FSM: idle, counting wait states, presenting a response.
  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam int unsigned WAIT_CNT_W = 4;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  // Byte address is misaligned or lies beyond the 2**addr_w word array.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned addr_w);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/inst_mem_resp_if.sv
// Fetch request/response handshake between the IF stage (master) and the memory (slave).
interface inst_mem_resp_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic [31:0]       req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              rsp_ready;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/imem_array.sv
// Word storage: one synchronous write port, one synchronous read port. A read and a write to
// the same word on the same edge return the old contents. The array is never reset.
module imem_array #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned WIDTH  = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Non-blocking write and read on the same edge give read-before-write ordering.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: serves word fetches over a valid/ready handshake after
// WAIT_CYC wait states, flags misaligned / out-of-range fetches, and accepts host writes.
// Optional build macro IMEM_PARITY_EN adds one even-parity bit per word, a prog_par_flip
// input to corrupt it on write, and reports parity mismatches through rsp_err.
module inst_mem_resp
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  inst_mem_resp_if.slave    bus,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
`ifdef IMEM_PARITY_EN
  input  logic              prog_par_flip,
`endif
  output logic              busy
);

`ifdef IMEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYC - 1);

  if (WAIT_CYC > (2**WAIT_CNT_W) - 1) begin : g_wait_chk
    $error("inst_mem_resp: WAIT_CYC=%0d exceeds 15", WAIT_CYC);
  end

  state_e                 state_q, state_d;
  logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   fault_q, fault_d;
  logic                   accept;
  logic                   rd_en;
  logic [ADDR_W-1:0]      rd_addr;
  logic [MEM_W-1:0]       rd_word;
  logic [MEM_W-1:0]       wr_word;
  logic                   par_err;

  assign bus.req_ready = (state_q == StIdle) || ((state_q == StResp) && bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  // Next-state logic: wait-state countdown, array read on entry to RESP, back-to-back accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    fault_d = fault_q;
    rd_en   = 1'b0;
    rd_addr = addr_q;

    unique case (state_q)
      StIdle: ;
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A new fetch overrides the above; only legal from IDLE or a completing RESP.
    if (accept) begin
      addr_d  = bus.req_addr[ADDR_W+1:2];
      fault_d = addr_fault(bus.req_addr, ADDR_W);
      if (WAIT_CYC == 0) begin
        state_d = StResp;
        rd_en   = 1'b1;
        rd_addr = bus.req_addr[ADDR_W+1:2];
      end else begin
        state_d = StWait;
        cnt_d   = WAIT_INIT;
      end
    end
  end

  // State register; reset silently abandons any outstanding fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      fault_q <= fault_d;
    end
  end

`ifdef IMEM_PARITY_EN
  // Stored bit makes each word even parity unless the host asks for a corrupted write.
  assign wr_word = {(^prog_data) ^ prog_par_flip, prog_data};
  assign par_err = ^rd_word;
`else
  assign wr_word = prog_data;
  assign par_err = 1'b0;
`endif

  imem_array #(
    .ADDR_W (ADDR_W),
    .WIDTH  (MEM_W)
  ) u_array (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (wr_word),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  // Response outputs are decoded from registered state, so they hold while RESP stalls.
  always_comb begin
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_err   = bus.rsp_valid && (fault_q || par_err);
    bus.rsp_data  = (bus.rsp_valid && !bus.rsp_err) ? rd_word[DATA_W-1:0] : DATA_W'(NOP);
    busy          = (state_q != StIdle);
  end

endmodule

// File: tb/tb_inst_mem_resp.sv
// Bench for inst_mem_resp: dut1 runs WAIT_CYC=1, dut0 runs WAIT_CYC=0. Expected responses
// come from a word-array model and are queued at accept, then popped when a response appears.
module tb_inst_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
`ifdef IMEM_PARITY_EN
  logic        prog_par_flip;
`endif
  logic        busy1, busy0;

  inst_mem_resp_if #(.DATA_W(32)) bus1 ();
  inst_mem_resp_if #(.DATA_W(32)) bus0 ();

  inst_mem_resp #(.ADDR_W(6), .DATA_W(32), .WAIT_CYC(1)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus1),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
`ifdef IMEM_PARITY_EN
    .prog_par_flip (prog_par_flip),
`endif
    .busy          (busy1)
  );

  inst_mem_resp #(.ADDR_W(6), .DATA_W(32), .WAIT_CYC(0)) dut0 (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus0),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
`ifdef IMEM_PARITY_EN
    .prog_par_flip (prog_par_flip),
`endif
    .busy          (busy0)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] q1 [$];
  logic [32:0] q0 [$];
  logic [31:0] mem_model [64];
  bit          par_bad [64];

  // Model of one response: {err, data}.
  function automatic logic [32:0] expect_rsp(input logic [31:0] a);
    if (a[1:0] != 2'b00 || (a >> 8) != 32'd0) return {1'b1, 32'h0};
    if (par_bad[a[7:2]]) return {1'b1, 32'h0};
    return {1'b0, mem_model[a[7:2]]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int w, input logic [31:0] d, input bit flip);
    prog_we   = 1'b1;
    prog_addr = w[5:0];
    prog_data = d;
`ifdef IMEM_PARITY_EN
    prog_par_flip = flip;
`endif
    tick();
    prog_we = 1'b0;
`ifdef IMEM_PARITY_EN
    prog_par_flip = 1'b0;
`endif
    mem_model[w] = d;
    par_bad[w]   = flip;
  endtask

  // Drive one request for a cycle from IDLE and queue what it should return.
  task automatic issue(input bit which, input logic [31:0] a);
    if (which) begin bus1.req_valid = 1'b1; bus1.req_addr = a; end
    else       begin bus0.req_valid = 1'b1; bus0.req_addr = a; end
    tick();
    if (which) begin bus1.req_valid = 1'b0; q1.push_back(expect_rsp(a)); end
    else       begin bus0.req_valid = 1'b0; q0.push_back(expect_rsp(a)); end
  endtask

  // Count cycles until rsp_valid, bounded.
  task automatic wait_rsp(input bit which, output int cyc);
    cyc = 0;
    while (((which ? bus1.rsp_valid : bus0.rsp_valid) !== 1'b1) && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++; if (bus1.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus1.req_ready); end
    n_checks++; if (bus1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus1.rsp_valid); end
    n_checks++; if (bus1.rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", bus1.rsp_data); end
    n_checks++; if (bus1.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", bus1.rsp_err); end
    n_checks++; if (busy1 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b%b want 00", busy1, busy0); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    int cyc;
    logic [32:0] e;
    for (int i = 0; i < 4; i++) prog(i, 32'h1111_0000 + i, 1'b0);
    prog(63, 32'hCAFE_F00D, 1'b0);
    issue(1'b1, 32'h8);
    wait_rsp(1'b1, cyc);
    n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL fetch_latency: got %0d want 1 after accept+1", cyc); end
    e = q1.pop_front();
    n_checks++; if (bus1.rsp_data !== e[31:0]) begin n_fail++; $display("FAIL fetch_data: got %h want %h", bus1.rsp_data, e[31:0]); end
    n_checks++; if (bus1.rsp_err !== e[32]) begin n_fail++; $display("FAIL fetch_err: got %b want %b", bus1.rsp_err, e[32]); end
    tick();
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL fetch_idle: busy got %b want 0", busy1); end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [32:0] e;
    bus1.rsp_ready = 1'b0;
    issue(1'b1, 32'h4);
    wait_rsp(1'b1, cyc);
    e = q1.pop_front();
    n_checks++; if (bus1.rsp_data !== e[31:0]) begin n_fail++; $display("FAIL stall_data: got %h want %h", bus1.rsp_data, e[31:0]); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_data !== e[31:0]) begin
        n_fail++; $display("FAIL stall_hold: valid %b data %h want 1 %h", bus1.rsp_valid, bus1.rsp_data, e[31:0]);
      end
      n_checks++; if (bus1.req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_req_ready: got %b want 0", bus1.req_ready); end
    end
    bus1.rsp_ready = 1'b1;
    bus1.req_valid = 1'b1;
    bus1.req_addr  = 32'hC;
    #1;
    n_checks++; if (bus1.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_req_ready: got %b want 1", bus1.req_ready); end
    tick();
    q1.push_back(expect_rsp(32'hC));
    bus1.req_valid = 1'b0;
    n_checks++; if (bus1.rsp_valid !== 1'b0 || busy1 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_wait: valid %b busy %b want 0 1", bus1.rsp_valid, busy1);
    end
    wait_rsp(1'b1, cyc);
    n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL b2b_latency: got %0d want 1", cyc); end
    e = q1.pop_front();
    n_checks++; if (bus1.rsp_data !== e[31:0]) begin n_fail++; $display("FAIL b2b_data: got %h want %h", bus1.rsp_data, e[31:0]); end
    tick();
  endtask

  task automatic test_fault();
    int cyc;
    logic [32:0] e;
    logic [31:0] addrs [4] = '{32'h6, 32'hFC, 32'h100, 32'h8000_0000};
    foreach (addrs[i]) begin
      issue(1'b1, addrs[i]);
      wait_rsp(1'b1, cyc);
      n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL fault_latency %h: got %0d want 1", addrs[i], cyc); end
      e = q1.pop_front();
      n_checks++; if (bus1.rsp_err !== e[32] || bus1.rsp_data !== e[31:0]) begin
        n_fail++; $display("FAIL fault_rsp %h: err %b data %h want %b %h", addrs[i], bus1.rsp_err, bus1.rsp_data, e[32], e[31:0]);
      end
      tick();
    end
  endtask

  task automatic test_read_before_write();
    int cyc;
    logic [32:0] e;
    issue(1'b1, 32'h8);
    prog_we   = 1'b1;
    prog_addr = 6'd2;
    prog_data = 32'hDEAD_BEEF;
    tick();
    prog_we      = 1'b0;
    mem_model[2] = 32'hDEAD_BEEF;
    e = q1.pop_front();
    n_checks++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_data !== e[31:0]) begin
      n_fail++; $display("FAIL rbw_old: valid %b data %h want 1 %h", bus1.rsp_valid, bus1.rsp_data, e[31:0]);
    end
    tick();
    issue(1'b1, 32'h8);
    wait_rsp(1'b1, cyc);
    e = q1.pop_front();
    n_checks++; if (bus1.rsp_data !== e[31:0]) begin n_fail++; $display("FAIL rbw_new: got %h want %h", bus1.rsp_data, e[31:0]); end
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [32:0] e;
    issue(1'b1, 32'h0);
    n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre: got %b want 1", busy1); end
    rst = 1'b1;
    tick();
    void'(q1.pop_back());
    n_checks++; if (bus1.rsp_valid !== 1'b0 || busy1 !== 1'b0 || bus1.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: valid %b busy %b ready %b want 0 0 1", bus1.rsp_valid, busy1, bus1.req_ready);
    end
    rst = 1'b0;
    repeat (2) tick();
    n_checks++; if (bus1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_dropped: valid got %b want 0", bus1.rsp_valid); end
    issue(1'b1, 32'h0);
    wait_rsp(1'b1, cyc);
    e = q1.pop_front();
    n_checks++; if (bus1.rsp_data !== e[31:0]) begin n_fail++; $display("FAIL mid_retained: got %h want %h", bus1.rsp_data, e[31:0]); end
    tick();
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    int cyc;
    logic [32:0] e;
    for (int k = 0; k < 2; k++) begin
      prog(1, 32'h1111_0001, (k == 0));
      issue(1'b1, 32'h4);
      wait_rsp(1'b1, cyc);
      e = q1.pop_front();
      n_checks++; if (bus1.rsp_err !== e[32] || bus1.rsp_data !== e[31:0]) begin
        n_fail++; $display("FAIL parity_%0d: err %b data %h want %b %h", k, bus1.rsp_err, bus1.rsp_data, e[32], e[31:0]);
      end
      tick();
    end
  endtask
`endif

  task automatic test_wait0_sweep();
    int cyc;
    logic [32:0] e;
    logic [31:0] addrs [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h6, 32'h100};
    foreach (addrs[i]) begin
      issue(1'b0, addrs[i]);
      wait_rsp(1'b0, cyc);
      n_checks++; if (cyc != 0) begin n_fail++; $display("FAIL w0_latency %h: extra cycles %0d want 0", addrs[i], cyc); end
      e = q0.pop_front();
      n_checks++; if (bus0.rsp_err !== e[32] || bus0.rsp_data !== e[31:0]) begin
        n_fail++; $display("FAIL w0_rsp %h: err %b data %h want %b %h", addrs[i], bus0.rsp_err, bus0.rsp_data, e[32], e[31:0]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e;
    logic [31:0] addrs [4] = '{32'hC, 32'h0, 32'hFC, 32'h4};
    bus0.req_valid = 1'b1;
    bus0.req_addr  = addrs[0];
    tick();
    q0.push_back(expect_rsp(addrs[0]));
    for (int i = 1; i < 4; i++) begin
      e = q0.pop_front();
      n_checks++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== e[31:0]) begin
        n_fail++; $display("FAIL b2b0_%0d: valid %b data %h want 1 %h", i, bus0.rsp_valid, bus0.rsp_data, e[31:0]);
      end
      bus0.req_addr = addrs[i];
      #1;
      n_checks++; if (bus0.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b0_ready_%0d: got %b want 1", i, bus0.req_ready); end
      tick();
      q0.push_back(expect_rsp(addrs[i]));
    end
    bus0.req_valid = 1'b0;
    e = q0.pop_front();
    n_checks++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== e[31:0]) begin
      n_fail++; $display("FAIL b2b0_last: valid %b data %h want 1 %h", bus0.rsp_valid, bus0.rsp_data, e[31:0]);
    end
    tick();
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL b2b0_idle: busy got %b want 0", busy0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    prog_we        = 1'b0;
    prog_addr      = '0;
    prog_data      = '0;
`ifdef IMEM_PARITY_EN
    prog_par_flip  = 1'b0;
`endif
    bus1.req_valid = 1'b0;
    bus1.req_addr  = '0;
    bus1.rsp_ready = 1'b1;
    bus0.req_valid = 1'b0;
    bus0.req_addr  = '0;
    bus0.rsp_ready = 1'b1;
    foreach (par_bad[i]) par_bad[i] = 1'b0;

    test_reset();
    test_fetch();
    test_backpressure();
    test_fault();
    test_read_before_write();
    test_reset_mid();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    test_wait0_sweep();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
